// File: rtl/dma_bus_arbiter_pkg.sv
// dma_bus_arbiter_pkg: shared state encoding and default limits for the DMA bus arbiter
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
package dma_bus_arbiter_pkg;
  localparam int WORD_SIZE = `WORD_SIZE;
  localparam int CMD_TIMEOUT_DEF = 8;
  localparam int MAX_GRANT_DEF = 32;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    WAIT_CPU = 3'd2,
    GRANT    = 3'd3,
    RELEASE  = 3'd4
  } state_t;
endpackage

// File: rtl/dma_bus_arbiter_timer.sv
// arb_timer: clearable up-counter that saturates at TERM and flags reaching it
module arb_timer #(
  parameter int W = 4,
  parameter int TERM = 7
) (
  input  logic CLK,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);
  logic [W-1:0] q;
  assign hit = q == W'(TERM);
  always_ff @(posedge CLK) begin
    if (reset || clr) q <= '0;
    else if (en && !hit) q <= q + W'(1);
  end
endmodule

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: sequences DMA commands and arbitrates the data-memory bus between CPU and DMA
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int CMD_TIMEOUT = CMD_TIMEOUT_DEF,
  parameter int MAX_GRANT = MAX_GRANT_DEF,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             dma_begin,
  input  logic             cpu_mem_busy,
  input  logic             BR,
  output logic             cmd,
  output logic             BG,
  output logic             cpu_bus_ok,
  output logic             dma_done_irq,
  output logic             err_timeout,
  output logic             err_overrun,
  output logic             err_grant,
  output logic [CNT_W-1:0] xfer_count
);
  localparam int CT_W = $clog2(CMD_TIMEOUT + 1);
  localparam int GT_W = $clog2(MAX_GRANT + 2);
  state_t state, state_n;
  logic pending, pending_n, overrun, ct_hit, gt_hit;
  arb_timer #(.W(CT_W), .TERM(CMD_TIMEOUT - 1)) u_cmd_timer (
    .CLK(CLK), .reset(reset), .clr(state != CMD), .en(state == CMD && !BR), .hit(ct_hit)
  );
  // grant watchdog trips once the count goes past MAX_GRANT
  arb_timer #(.W(GT_W), .TERM(MAX_GRANT + 1)) u_grant_timer (
    .CLK(CLK), .reset(reset), .clr(state != GRANT), .en(state == GRANT), .hit(gt_hit)
  );
  assign cmd = state inside {CMD, WAIT_CPU, GRANT};
  assign cpu_bus_ok = (state inside {IDLE, CMD, WAIT_CPU}) && !BG;
  assign overrun = dma_begin && state != IDLE && pending;
  assign pending_n = (state == IDLE || (state == RELEASE && pending)) ? 1'b0 : pending | dma_begin;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = (dma_begin || pending) ? CMD : IDLE;
      CMD:      state_n = BR ? WAIT_CPU : ct_hit ? IDLE : CMD;
      WAIT_CPU: state_n = !BR ? IDLE : cpu_mem_busy ? WAIT_CPU : GRANT;
      GRANT:    state_n = BR ? GRANT : RELEASE;
      RELEASE:  state_n = pending ? CMD : IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      BG <= 1'b0;
      dma_done_irq <= 1'b0;
      pending <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      err_grant <= 1'b0;
      xfer_count <= '0;
    end else begin
      state <= state_n;
      BG <= state_n == GRANT;
      dma_done_irq <= state_n == RELEASE;
      pending <= pending_n;
      err_timeout <= err_timeout | (state == CMD && !BR && ct_hit);
      err_overrun <= err_overrun | overrun;
      err_grant <= err_grant | (state == GRANT && gt_hit);
      xfer_count <= xfer_count + CNT_W'(state_n == RELEASE);
    end
  end
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter: directed self-checking bench for the DMA bus arbiter
module tb_dma_bus_arbiter;
  logic CLK = 1'b0, reset, dma_begin, cpu_mem_busy, BR;
  logic cmd, BG, cpu_bus_ok, dma_done_irq, err_timeout, err_overrun, err_grant;
  logic [7:0] xfer_count;
  int checks = 0, failures = 0;
  dma_bus_arbiter #(.CMD_TIMEOUT(8), .MAX_GRANT(32), .CNT_W(8)) dut (
    .CLK(CLK), .reset(reset), .dma_begin(dma_begin), .cpu_mem_busy(cpu_mem_busy), .BR(BR),
    .cmd(cmd), .BG(BG), .cpu_bus_ok(cpu_bus_ok), .dma_done_irq(dma_done_irq),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .err_grant(err_grant),
    .xfer_count(xfer_count)
  );
  always #5 CLK = ~CLK;
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1; dma_begin = 1'b0; cpu_mem_busy = 1'b0; BR = 1'b0;
    step(); step();
    chk("rst_cmd", cmd, 0); chk("rst_bg", BG, 0); chk("rst_ok", cpu_bus_ok, 1);
    chk("rst_irq", dma_done_irq, 0); chk("rst_cnt", xfer_count, 0);
    chk("rst_errs", {err_timeout, err_overrun, err_grant}, 0);
    reset = 1'b0;
    step();
    dma_begin = 1'b1; step(); dma_begin = 1'b0;
    chk("t1_cmd_up", cmd, 1); chk("t1_bg_cmd", BG, 0); chk("t1_ok_cmd", cpu_bus_ok, 1);
    BR = 1'b1; step();
    chk("t1_wait_cmd", cmd, 1); chk("t1_wait_bg", BG, 0);
    step();
    chk("t1_bg_up", BG, 1); chk("t1_ok_down", cpu_bus_ok, 0);
    for (int i = 0; i < 10; i++) begin
      step(); chk("t1_bg_hold", BG, 1);
    end
    BR = 1'b0; step();
    chk("t1_rel_bg", BG, 0); chk("t1_rel_cmd", cmd, 0); chk("t1_rel_irq", dma_done_irq, 1);
    chk("t1_rel_ok", cpu_bus_ok, 0);
    step();
    chk("t1_irq_once", dma_done_irq, 0); chk("t1_cnt", xfer_count, 1); chk("t1_idle_ok", cpu_bus_ok, 1);
    dma_begin = 1'b1; step(); dma_begin = 1'b0;
    BR = 1'b1; cpu_mem_busy = 1'b1; step();
    for (int i = 0; i < 4; i++) begin
      step(); chk("t2_bg_blocked", BG, 0); chk("t2_cmd_wait", cmd, 1);
    end
    cpu_mem_busy = 1'b0; step();
    chk("t2_bg_after_busy", BG, 1);
    BR = 1'b0; step(); step();
    chk("t2_cnt", xfer_count, 2);
    dma_begin = 1'b1; step(); dma_begin = 1'b0;
    BR = 1'b1; cpu_mem_busy = 1'b1; step();
    BR = 1'b0; step();
    chk("t3_spur_cmd", cmd, 0); chk("t3_spur_irq", dma_done_irq, 0);
    cpu_mem_busy = 1'b0; step();
    chk("t3_spur_irq2", dma_done_irq, 0); chk("t3_spur_cnt", xfer_count, 2);
    dma_begin = 1'b1; step(); dma_begin = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("t4_cmd_8th", cmd, 1); chk("t4_no_err_yet", err_timeout, 0); chk("t4_bg_cmd", BG, 0);
    step();
    chk("t4_err", err_timeout, 1); chk("t4_cmd_off", cmd, 0); chk("t4_bg", BG, 0);
    step();
    chk("t4_sticky", err_timeout, 1); chk("t4_idle", cmd, 0);
    dma_begin = 1'b1; step(); dma_begin = 1'b0;
    BR = 1'b1; step(); step();
    chk("t5_bg", BG, 1);
    dma_begin = 1'b1; step(); dma_begin = 1'b0;
    chk("t5_no_ovr", err_overrun, 0);
    step();
    dma_begin = 1'b1; step(); dma_begin = 1'b0;
    chk("t5_ovr", err_overrun, 1); chk("t5_bg_kept", BG, 1);
    BR = 1'b0; step();
    chk("t5_irq", dma_done_irq, 1);
    step();
    chk("t5_recmd", cmd, 1); chk("t5_irq_off", dma_done_irq, 0); chk("t5_cnt3", xfer_count, 3);
    BR = 1'b1; step(); step();
    chk("t5_bg2", BG, 1);
    BR = 1'b0; step(); step();
    chk("t5_cnt4", xfer_count, 4); chk("t5_dropped", cmd, 0);
    step();
    chk("t5_dropped2", cmd, 0);
    dma_begin = 1'b1; step(); dma_begin = 1'b0;
    BR = 1'b1; step(); step();
    chk("t6_bg", BG, 1);
    reset = 1'b1; step();
    chk("t6_bg", BG, 0); chk("t6_cmd", cmd, 0); chk("t6_cnt", xfer_count, 0);
    chk("t6_irq", dma_done_irq, 0); chk("t6_errs", {err_timeout, err_overrun, err_grant}, 0);
    reset = 1'b0; BR = 1'b0; step();
    chk("t6_irq2", dma_done_irq, 0); chk("t6_cnt2", xfer_count, 0);
    dma_begin = 1'b1; step(); dma_begin = 1'b0;
    BR = 1'b1; step(); step();
    for (int i = 0; i < 29; i++) step();
    chk("t7_bg30", BG, 1); chk("t7_no_err30", err_grant, 0);
    for (int i = 0; i < 10; i++) step();
    chk("t7_err", err_grant, 1); chk("t7_bg_kept", BG, 1);
    BR = 1'b0; step();
    chk("t7_irq", dma_done_irq, 1);
    dma_begin = 1'b1; step(); dma_begin = 1'b0;
    chk("t8_idle", cmd, 0); chk("t8_cnt", xfer_count, 1); chk("t8_ok", cpu_bus_ok, 1);
    step();
    chk("t8_recmd", cmd, 1); chk("t8_err_sticky", err_grant, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Sequences the DMA engine and arbitrates the shared data-memory bus between the CPU and the DMA.
- Accepts a transfer request from the external device, raises the DMA command, and waits for the DMA bus request.
- Grants the bus only when the CPU has no memory access in flight, holds the grant until the DMA releases its request, then signals completion to the CPU.
- Sits between the CPU memory interface, the external device and the DMA block.

Parameters:
- CMD_TIMEOUT, 8: maximum cycles in CMD waiting for BR before aborting.
- MAX_GRANT, 32: grant-length watchdog threshold in cycles; flag only, never revokes.
- CNT_W, 8: width of the completed-transfer counter.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- dma_begin  in  1  one-cycle request pulse from the external device.
- cpu_mem_busy  in  1  CPU has a memory access in flight this cycle.
- BR  in  1  bus request from the DMA.
- cmd  out  1  DMA command level.
- BG  out  1  bus grant to the DMA; registered.
- cpu_bus_ok  out  1  CPU may drive the memory bus; combinational, equals (state is IDLE, CMD or WAIT_CPU) and not BG.
- dma_done_irq  out  1  one-cycle completion interrupt to the CPU.
- err_timeout  out  1  sticky: BR never arrived within CMD_TIMEOUT.
- err_overrun  out  1  sticky: dma_begin arrived while a request was already pending.
- err_grant  out  1  sticky: grant lasted more than MAX_GRANT cycles.
- xfer_count  out  CNT_W  completed transfers; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, cmd=0, BG=0, dma_done_irq=0, all err flags=0, xfer_count=0, pending=0, timers=0. Reset overrides everything, including mid-GRANT; BG drops on the next edge.
- States: IDLE, CMD, WAIT_CPU, GRANT, RELEASE.
- IDLE: on dma_begin or pending -> CMD; clear pending; load timer=0.
- CMD: cmd=1.
  - If BR=1 -> WAIT_CPU.
  - Else timer++; when timer reaches CMD_TIMEOUT-1 -> set err_timeout and go to IDLE with cmd=0.
- WAIT_CPU: cmd=1. If cpu_mem_busy=0 -> GRANT, with BG registered to 1 on that edge. Otherwise stay; no timeout in this state.
- GRANT: cmd=1, BG=1. The grant timer increments every cycle.
  - If the timer exceeds MAX_GRANT -> set err_grant, stay in GRANT.
  - If BR=0 -> RELEASE; BG=0 and cmd=0 on that edge.
- RELEASE (1 cycle): BG=0, cmd=0, dma_done_irq=1, xfer_count++.
  - Next state is CMD if pending=1 (clear pending), else IDLE.
- Latency:
  - dma_begin in IDLE -> cmd high the next cycle.
  - BR with cpu_mem_busy=0 -> BG high 2 cycles after BR is first seen (CMD->WAIT_CPU->GRANT).
  - BR fall -> BG low the next cycle; dma_done_irq follows in the same cycle.
- Pending queue is one deep.
  - dma_begin in any state other than IDLE sets pending.
  - If pending is already 1, set err_overrun and drop the request.
  - dma_begin in the same cycle as the RELEASE->IDLE transition sets pending; the next request starts from IDLE one cycle later.
- BG is never 1 in the same cycle as cpu_bus_ok=1.
- BG only rises from WAIT_CPU with cpu_mem_busy=0 sampled on that edge.
- A BR deassert during WAIT_CPU (spurious) -> return to IDLE, no irq, no count.
- Sticky errors clear only on reset.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, CMD=1, WAIT_CPU=2, GRANT=3, RELEASE=4; 3-bit);
  - the CMD_TIMEOUT and MAX_GRANT defaults;
  - the common WORD_SIZE define.
- One sub-module, arb_timer: a resettable up-counter with load-clear, enable and a terminal-compare output. It is instantiated twice, once for the command timeout and once for the grant watchdog.

Test Plan:
- Reset, then a dma_begin pulse at cycle 2; BR=1 at cycle 4; cpu_mem_busy=0 -> cmd=1 from cycle 3, BG=1 at cycle 6, cpu_bus_ok=0 from cycle 6.
- DMA holds BR for 12 cycles then drops it -> BG=0 and dma_done_irq=1 for exactly one cycle; xfer_count=1; cmd=0.
- cpu_mem_busy=1 for 5 cycles after BR rises -> BG stays 0 throughout; BG=1 exactly one cycle after cpu_mem_busy falls.
- dma_begin with BR never asserted, CMD_TIMEOUT=8 -> err_timeout=1 after 8 cycles in CMD; state IDLE; cmd=0; BG never 1.
- Two dma_begin pulses during GRANT -> the first sets pending and the second sets err_overrun; after RELEASE the arbiter re-enters CMD immediately; xfer_count reaches 2 after the second BR cycle.
- Reset asserted mid-GRANT with BR=1 -> next cycle BG=0, cmd=0, xfer_count=0, no dma_done_irq; BR held high beyond MAX_GRANT in a separate run -> err_grant=1 while BG stays 1.
